// File: rtl/uart_pix_pkg.sv
// Shared definitions for the UART-to-pixel packer: FSM states, sync header bytes
// and pixel format selectors.
package uart_pix_pkg;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    HDR1  = 2'd1,
    BYTE0 = 2'd2,
    BYTE1 = 2'd3
  } pix_state_e;

  localparam logic [7:0] SYNC0 = 8'h55;
  localparam logic [7:0] SYNC1 = 8'hAA;

  localparam int MODE_RGB332 = 0;
  localparam int MODE_RGB565 = 1;

endpackage

// File: rtl/rgb332_to_565.sv
// Combinational RGB332 -> RGB565 expander; low bits are filled by replicating the
// top bits so full-scale inputs map to full-scale outputs.
module rgb332_to_565
  import uart_pix_pkg::*;
(
  input  logic [7:0]  rgb332,
  output logic [15:0] rgb565
);

  assign rgb565 = {rgb332[7:5], rgb332[7:6],
                   rgb332[4:2], rgb332[4:2],
                   rgb332[1:0], rgb332[1:0], rgb332[1]};

endmodule

// File: rtl/uart_pixel_packer.sv
// Packs the UART byte stream into RGB565 pixels with linear frame addresses,
// optional sync-header framing, a ready/valid output and sticky error flags.
module uart_pixel_packer
  import uart_pix_pkg::*;
#(
  parameter int H_PIXEL     = 640,
  parameter int V_PIXEL     = 480,
  parameter int ADDR_W      = 24,
  parameter int MODE        = 0,
  parameter int SYNC_EN     = 1,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_flag,
  input  logic              wr_ready,
  input  logic              clr_err,
  output logic [15:0]       pix_data,
  output logic              pix_valid,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              sof,
  output logic              frame_done,
  output logic              err_overrun,
  output logic              err_timeout
);

  localparam int                TMO_W      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(H_PIXEL * V_PIXEL - 1);
  localparam pix_state_e        IDLE_STATE = (SYNC_EN != 0) ? HUNT : BYTE0;

  pix_state_e        state_reg, state_next;
  logic [TMO_W-1:0]  tmo_cnt_reg, tmo_cnt_next;
  logic [7:0]        hi_reg, hi_next;
  logic [15:0]       pix_data_reg, pix_data_next;
  logic              pix_valid_reg, pix_valid_next;
  logic [ADDR_W-1:0] pix_addr_reg, pix_addr_next;
  logic              err_overrun_reg, err_overrun_next;
  logic              err_timeout_reg, err_timeout_next;

  logic [15:0] expanded;
  logic        complete, accept, overrun, tmo_hit;
  logic        transfer, last_xfer;

  generate
    if (MODE == MODE_RGB332) begin : g_rgb332
      rgb332_to_565 u_expand (
        .rgb332 (in_data),
        .rgb565 (expanded)
      );
    end else begin : g_rgb565
      assign expanded = {hi_reg, in_data};
    end
  endgenerate

  assign transfer  = pix_valid_reg & wr_ready;
  assign last_xfer = transfer && (pix_addr_reg == LAST_ADDR);

  always_comb begin
    state_next   = state_reg;
    hi_next      = hi_reg;
    tmo_cnt_next = '0;
    tmo_hit      = 1'b0;
    complete     = 1'b0;

    // Idle counter only matters while a header or pixel is half received.
    if ((state_reg == HDR1 || state_reg == BYTE1) && !in_flag) begin
      if (tmo_cnt_reg == TMO_LAST) tmo_hit = 1'b1;
      else                         tmo_cnt_next = tmo_cnt_reg + 1'b1;
    end

    case (state_reg)
      HUNT: begin
        if (in_flag && in_data == SYNC0) state_next = HDR1;
      end
      HDR1: begin
        if (in_flag) begin
          if (in_data == SYNC1)      state_next = BYTE0;
          else if (in_data != SYNC0) state_next = HUNT;
        end else if (tmo_hit) begin
          state_next = HUNT;
        end
      end
      BYTE0: begin
        if (in_flag) begin
          if (MODE == MODE_RGB332) begin
            complete = 1'b1;
          end else begin
            hi_next    = in_data;
            state_next = BYTE1;
          end
        end
      end
      BYTE1: begin
        if (in_flag) begin
          complete   = 1'b1;
          state_next = BYTE0;
        end else if (tmo_hit) begin
          hi_next    = '0;
          state_next = BYTE0;
        end
      end
      default: state_next = IDLE_STATE;
    endcase

    // End of frame: the next frame must announce itself with a fresh header.
    if (last_xfer && SYNC_EN != 0) state_next = HUNT;
  end

  always_comb begin
    overrun = complete && pix_valid_reg && !wr_ready;
    // A byte completing a pixel as the frame closes has no frame to land in.
    accept  = complete && !overrun && !(last_xfer && SYNC_EN != 0);

    pix_valid_next = accept | (pix_valid_reg & ~transfer);
    pix_data_next  = accept ? expanded : pix_data_reg;

    pix_addr_next = pix_addr_reg;
    if (transfer) pix_addr_next = last_xfer ? '0 : pix_addr_reg + 1'b1;

    err_overrun_next = overrun | (err_overrun_reg & ~clr_err);
    err_timeout_next = tmo_hit | (err_timeout_reg & ~clr_err);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg       <= IDLE_STATE;
      tmo_cnt_reg     <= '0;
      hi_reg          <= '0;
      pix_data_reg    <= '0;
      pix_valid_reg   <= 1'b0;
      pix_addr_reg    <= '0;
      err_overrun_reg <= 1'b0;
      err_timeout_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      tmo_cnt_reg     <= tmo_cnt_next;
      hi_reg          <= hi_next;
      pix_data_reg    <= pix_data_next;
      pix_valid_reg   <= pix_valid_next;
      pix_addr_reg    <= pix_addr_next;
      err_overrun_reg <= err_overrun_next;
      err_timeout_reg <= err_timeout_next;
    end
  end

  assign pix_data    = pix_data_reg;
  assign pix_valid   = pix_valid_reg;
  assign pix_addr    = pix_addr_reg;
  assign sof         = transfer && (pix_addr_reg == '0);
  assign frame_done  = last_xfer;
  assign err_overrun = err_overrun_reg;
  assign err_timeout = err_timeout_reg;

endmodule

// File: tb/tb_uart_pixel_packer.sv
// Scoreboard bench: instance 0 runs RGB332, instance 1 runs RGB565, both with a
// 4x2 frame so address wrap and header re-sync are exercised quickly.
module tb_uart_pixel_packer;

  localparam int TO     = 20;
  localparam int NPIX   = 8;
  localparam int ADDR_W = 24;

  typedef struct packed {
    logic [15:0]       data;
    logic [ADDR_W-1:0] addr;
    logic              sof;
    logic              fd;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n       [2];
  logic [7:0]        in_data     [2];
  logic              in_flag     [2];
  logic              wr_ready    [2];
  logic              clr_err     [2];
  logic [15:0]       pix_data    [2];
  logic              pix_valid   [2];
  logic [ADDR_W-1:0] pix_addr    [2];
  logic              sof         [2];
  logic              frame_done  [2];
  logic              err_overrun [2];
  logic              err_timeout [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      uart_pixel_packer #(
        .H_PIXEL(4), .V_PIXEL(2), .ADDR_W(ADDR_W),
        .MODE(gi), .SYNC_EN(1), .TIMEOUT_CYC(TO)
      ) u_dut (
        .sys_clk     (clk),
        .sys_rst_n   (rst_n[gi]),
        .in_data     (in_data[gi]),
        .in_flag     (in_flag[gi]),
        .wr_ready    (wr_ready[gi]),
        .clr_err     (clr_err[gi]),
        .pix_data    (pix_data[gi]),
        .pix_valid   (pix_valid[gi]),
        .pix_addr    (pix_addr[gi]),
        .sof         (sof[gi]),
        .frame_done  (frame_done[gi]),
        .err_overrun (err_overrun[gi]),
        .err_timeout (err_timeout[gi])
      );
    end
  endgenerate

  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_addr [2];
  exp_t exp_q0 [$];
  exp_t exp_q1 [$];

  // Reference colour expansion: scale each channel by replicating its MSBs.
  function automatic logic [15:0] exp332(input logic [7:0] b);
    int r, g, bl;
    r  = int'(b[7:5]);
    g  = int'(b[4:2]);
    bl = int'(b[1:0]);
    return 16'((((r << 2) | (r >> 1)) << 11) |
               (((g << 3) | g) << 5) |
               ((bl << 3) | (bl << 1) | (bl >> 1)));
  endfunction

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h, required %0h", name, d, act, req);
    end
  endtask

  task automatic push_pix(input int d, input logic [15:0] v);
    exp_t e;
    e.data = (d == 0) ? exp332(v[7:0]) : v;
    e.addr = ADDR_W'(m_addr[d]);
    e.sof  = (m_addr[d] == 0);
    e.fd   = (m_addr[d] == NPIX - 1);
    m_addr[d] = (m_addr[d] + 1) % NPIX;
    if (d == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_raw(input int d, input logic [7:0] b);
    @(posedge clk);
    #1;
    in_data[d] = b;
    in_flag[d] = 1'b1;
    @(posedge clk);
    #1;
    in_flag[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d, input bit rnd);
    int cnt;
    cnt = 0;
    while (pix_valid[d]) begin
      if (rnd) wr_ready[d] = ($urandom_range(0, 3) != 0);
      tick(1);
      cnt++;
      if (cnt > 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL wait_idle dut%0d: pix_valid still 1 after %0d cycles, required 0", d, cnt);
        break;
      end
    end
  endtask

  task automatic send_byte(input int d, input logic [7:0] b, input bit rnd);
    wait_idle(d, rnd);
    send_raw(d, b);
  endtask

  task automatic send_pixel(input int d, input logic [15:0] v, input bit rnd);
    push_pix(d, v);
    if (d == 0) begin
      send_byte(0, v[7:0], rnd);
    end else begin
      send_byte(1, v[15:8], rnd);
      send_byte(1, v[7:0], rnd);
    end
  endtask

  task automatic header(input int d, input bit rnd);
    send_byte(d, 8'h55, rnd);
    send_byte(d, 8'hAA, rnd);
  endtask

  task automatic pulse_clr(input int d);
    @(posedge clk);
    #1;
    clr_err[d] = 1'b1;
    tick(1);
    clr_err[d] = 1'b0;
  endtask

  task automatic fill_frame(input int d);
    while (m_addr[d] != 0) send_pixel(d, 16'($urandom), 1'b0);
    wait_idle(d, 1'b0);
  endtask

  task automatic rand_frames(input int d, input int n);
    int ng;
    logic [7:0] g;
    for (int f = 0; f < n; f++) begin
      ng = $urandom_range(0, 3);
      for (int k = 0; k < ng; k++) begin
        do g = 8'($urandom); while (g == 8'h55);
        send_byte(d, g, 1'b1);
      end
      header(d, 1'b1);
      for (int p = 0; p < NPIX; p++) begin
        send_pixel(d, 16'($urandom), 1'b1);
        repeat ($urandom_range(0, 3)) begin
          wr_ready[d] = ($urandom_range(0, 3) != 0);
          tick(1);
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input int d);
    check("rst_pix_valid", d, 32'(pix_valid[d]), 32'd0);
    check("rst_pix_addr", d, 32'(pix_addr[d]), 32'd0);
    check("rst_pix_data", d, 32'(pix_data[d]), 32'd0);
    check("rst_sof", d, 32'(sof[d]), 32'd0);
    check("rst_frame_done", d, 32'(frame_done[d]), 32'd0);
    check("rst_err_overrun", d, 32'(err_overrun[d]), 32'd0);
    check("rst_err_timeout", d, 32'(err_timeout[d]), 32'd0);
  endtask

  // Scoreboard monitor: every handshake pops one expected pixel.
  task automatic monitor();
    exp_t e, g;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (pix_valid[d] && wr_ready[d]) begin
          g.data = pix_data[d];
          g.addr = pix_addr[d];
          g.sof  = sof[d];
          g.fd   = frame_done[d];
          n_checks++;
          if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
            n_fail++;
            $display("FAIL unexpected_pixel dut%0d: got data=%h addr=%0d, required no transfer", d, g.data, g.addr);
          end else begin
            if (d == 0) e = exp_q0.pop_front();
            else        e = exp_q1.pop_front();
            if (g !== e) begin
              n_fail++;
              $display("FAIL pixel dut%0d: got data=%h addr=%0d sof=%0b fd=%0b, required data=%h addr=%0d sof=%0b fd=%0b",
                       d, g.data, g.addr, g.sof, g.fd, e.data, e.addr, e.sof, e.fd);
            end else begin
              $display("dut%0d pixel %h addr %0d sof %0b fd %0b ok", d, g.data, g.addr, g.sof, g.fd);
            end
          end
        end else if (sof[d] || frame_done[d]) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_pulse dut%0d: got sof=%0b fd=%0b, required 0 without transfer", d, sof[d], frame_done[d]);
        end
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; in_data[d] = '0; in_flag[d] = 1'b0;
      wr_ready[d] = 1'b0; clr_err[d] = 1'b0; m_addr[d] = 0;
    end
    tick(3);
    check_reset_outputs(0);
    check_reset_outputs(1);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    fork
      monitor();
    join_none

    // ---- RGB332 instance ----
    wr_ready[0] = 1'b1;
    header(0, 1'b0);
    send_pixel(0, 16'h00E0, 1'b0);
    send_pixel(0, 16'h001C, 1'b0);
    send_pixel(0, 16'h0003, 1'b0);
    wait_idle(0, 1'b0);
    check("no_overrun", 0, 32'(err_overrun[0]), 32'd0);

    // Overrun: first pixel held, second dropped.
    wr_ready[0] = 1'b0;
    push_pix(0, 16'h0092);
    send_raw(0, 8'h92);
    send_raw(0, 8'h49);
    check("ovr_flag", 0, 32'(err_overrun[0]), 32'd1);
    check("ovr_valid", 0, 32'(pix_valid[0]), 32'd1);
    check("ovr_data_held", 0, 32'(pix_data[0]), 32'(exp332(8'h92)));
    check("ovr_addr_held", 0, 32'(pix_addr[0]), 32'd3);
    wr_ready[0] = 1'b1;
    wait_idle(0, 1'b0);
    check("ovr_addr_next", 0, 32'(pix_addr[0]), 32'd4);
    pulse_clr(0);
    check("ovr_cleared", 0, 32'(err_overrun[0]), 32'd0);

    // Frame end, wrap, headerless bytes ignored.
    fill_frame(0);
    check("wrap_addr", 0, 32'(pix_addr[0]), 32'd0);
    send_byte(0, 8'h12, 1'b0);
    send_byte(0, 8'h34, 1'b0);
    send_byte(0, 8'hA5, 1'b0);
    tick(3);
    check("no_hdr_ignored", 0, 32'(pix_valid[0]), 32'd0);

    // Header robustness.
    send_byte(0, 8'h55, 1'b0);
    header(0, 1'b0);
    send_pixel(0, 16'h0012, 1'b0);
    fill_frame(0);
    send_byte(0, 8'h55, 1'b0);
    send_byte(0, 8'h12, 1'b0);
    send_byte(0, 8'hAA, 1'b0);
    send_byte(0, 8'h34, 1'b0);
    tick(3);
    check("bad_hdr_ignored", 0, 32'(pix_valid[0]), 32'd0);

    // Partial header abandoned.
    send_byte(0, 8'h55, 1'b0);
    tick(TO + 5);
    check("hdr_timeout", 0, 32'(err_timeout[0]), 32'd1);
    send_byte(0, 8'hAA, 1'b0);
    send_byte(0, 8'h34, 1'b0);
    tick(3);
    check("hdr_tmo_hunt", 0, 32'(pix_valid[0]), 32'd0);
    pulse_clr(0);
    check("tmo_cleared", 0, 32'(err_timeout[0]), 32'd0);

    rand_frames(0, 6);
    wr_ready[0] = 1'b1;

    // ---- RGB565 instance ----
    wr_ready[1] = 1'b1;
    header(1, 1'b0);
    send_pixel(1, 16'hF800, 1'b0);
    send_pixel(1, 16'h07E0, 1'b0);
    send_byte(1, 8'h12, 1'b0);
    tick(TO + 5);
    check("byte_timeout", 1, 32'(err_timeout[1]), 32'd1);
    check("byte_tmo_nopix", 1, 32'(pix_valid[1]), 32'd0);
    send_pixel(1, 16'h3456, 1'b0);
    pulse_clr(1);
    check("tmo_cleared", 1, 32'(err_timeout[1]), 32'd0);

    // Slow but within the idle limit: still a valid pixel.
    push_pix(1, 16'h5678);
    send_byte(1, 8'h56, 1'b0);
    tick(TO - 3);
    send_byte(1, 8'h78, 1'b0);
    wait_idle(1, 1'b0);
    check("slow_no_tmo", 1, 32'(err_timeout[1]), 32'd0);

    // Last pixel accepted while a high byte is pending: FSM must drop to HUNT.
    for (int k = 0; k < 3; k++) send_pixel(1, 16'($urandom), 1'b0);
    wait_idle(1, 1'b0);
    wr_ready[1] = 1'b0;
    send_pixel(1, 16'hBEEF, 1'b0);
    send_raw(1, 8'h9A);
    check("last_held_addr", 1, 32'(pix_addr[1]), 32'd7);
    check("last_held_valid", 1, 32'(pix_valid[1]), 32'd1);
    wr_ready[1] = 1'b1;
    wait_idle(1, 1'b0);
    check("wrap_addr", 1, 32'(pix_addr[1]), 32'd0);
    send_raw(1, 8'h3C);
    tick(TO + 5);
    check("forced_hunt_nopix", 1, 32'(pix_valid[1]), 32'd0);
    check("forced_hunt_no_tmo", 1, 32'(err_timeout[1]), 32'd0);
    header(1, 1'b0);
    send_pixel(1, 16'hC0DE, 1'b0);
    wait_idle(1, 1'b0);

    // Asynchronous reset with a held pixel and a pending high byte.
    wr_ready[1] = 1'b0;
    send_pixel(1, 16'h1234, 1'b0);
    send_raw(1, 8'h77);
    @(posedge clk);
    #2;
    rst_n[1] = 1'b0;
    #1;
    check_reset_outputs(1);
    exp_q1.delete();
    m_addr[1] = 0;
    @(posedge clk);
    #1;
    rst_n[1] = 1'b1;
    wr_ready[1] = 1'b1;
    send_raw(1, 8'h88);
    tick(3);
    check("post_rst_hunt", 1, 32'(pix_valid[1]), 32'd0);
    header(1, 1'b0);
    send_pixel(1, 16'hA5C3, 1'b0);
    fill_frame(1);

    rand_frames(1, 6);

    wr_ready[0] = 1'b1;
    wr_ready[1] = 1'b1;
    tick(20);
    check("queue_drained", 0, 32'(exp_q0.size()), 32'd0);
    check("queue_drained", 1, 32'(exp_q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
